// File: rtl/rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter
//
// Round-robin arbiter sharing one resource among N requesters over a req/gnt
// handshake. Each grant is held for at most MAX_HOLD consecutive cycles, and
// every release is followed by exactly one cycle with no owner.
//
// Parameters:
//   N        - number of requesters (2..16)
//   MAX_HOLD - maximum consecutive cycles a grant may be held (>= 1)
//   IDW      - width of o_gnt_id
//   CW       - width of the internal hold counter
//
// Ports:
//   i_clk     - clock, rising edge
//   i_rst     - asynchronous active-high reset
//   i_req     - per-requester request level, held until served
//   i_done    - per-requester release pulse, only honoured for the owner
//   o_gnt     - registered one-hot grant, all-zero when idle
//   o_gnt_id  - index of the current owner, valid while o_ok = 1
//   o_ok      - resource currently owned (= |o_gnt)
//   o_timeout - one-cycle pulse when a grant is revoked by the hold limit
//
// Optional build macro:
//   ARB_SVA_EN - when defined, compiles concurrent protocol assertions.
//                Behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module rr_req_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned IDW      = $clog2(N),
    parameter int unsigned CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req,
    input  logic [N-1:0]   i_done,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_ok,
    output logic           o_timeout
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic           r_ok;
    logic           r_timeout;

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic           w_found;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_sel;
    logic [N-1:0]   w_sel_oh;
    logic           w_own_req;
    logic           w_own_done;
    logic           w_limit;
    logic           w_end;
    logic [IDW-1:0] w_ptr_nxt;

    // Rotate requests so that bit 0 corresponds to r_ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = N'(w_req2 >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
    end

    // (ptr + offset) mod N, with one spare bit so non-power-of-two N wraps.
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW + 1)'(N)) begin
            w_sum = w_sum - (IDW + 1)'(N);
        end
        w_sel = w_sum[IDW-1:0];
    end

    assign w_sel_oh = {{(N - 1){1'b0}}, 1'b1} << w_sel;

    // Only the owner's req/done matter while a grant is active.
    assign w_own_req  = i_req[r_gnt_id];
    assign w_own_done = i_done[r_gnt_id];
    assign w_limit    = (r_cnt == CW'(MAX_HOLD));
    assign w_end      = w_own_done || !w_own_req || w_limit;
    assign w_ptr_nxt  = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ok      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                StIdle, StGap: begin
                    if (w_found) begin
                        r_gnt    <= w_sel_oh;
                        r_gnt_id <= w_sel;
                        r_ok     <= 1'b1;
                        r_cnt    <= CW'(1);
                        r_state  <= StGrant;
                    end else begin
                        r_state  <= StIdle;
                    end
                end
                StGrant: begin
                    if (w_end) begin
                        r_gnt     <= '0;
                        r_ok      <= 1'b0;
                        r_ptr     <= w_ptr_nxt;
                        r_state   <= StGap;
                        // A voluntary release in the limit cycle is not a timeout.
                        r_timeout <= w_limit && !w_own_done && w_own_req;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_ok    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_ok      = r_ok;
    assign o_timeout = r_timeout;

`ifdef ARB_SVA_EN
    a_onehot : assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_gnt));

    a_id_match : assert property (@(posedge i_clk) disable iff (i_rst)
        o_ok |-> o_gnt[o_gnt_id]);

    // An owner change always passes through a cycle with no owner.
    a_gap : assert property (@(posedge i_clk) disable iff (i_rst)
        (o_ok && $past(o_ok)) |-> (o_gnt == $past(o_gnt)));

    a_timeout_drop : assert property (@(posedge i_clk) disable iff (i_rst)
        o_timeout |-> $fell(o_ok));

    for (genvar gi = 0; gi < N; gi++) begin : g_sva
        a_gnt_after_req : assert property (@(posedge i_clk) disable iff (i_rst)
            (o_gnt[gi] && !$past(o_gnt[gi])) |-> $past(i_req[gi]));

        a_hold_limit : assert property (@(posedge i_clk) disable iff (i_rst)
            o_gnt[gi] |-> not (o_gnt[gi] [* MAX_HOLD + 1]));

        a_served : assert property (@(posedge i_clk) disable iff (i_rst)
            i_req[gi] |-> s_eventually (o_gnt[gi] || !i_req[gi]));
    end
`endif

endmodule
